// File: rtl/evaluate_taper.sv
// Collects NUM_EVALS signed mg/eg pairs once every evaluator reports valid, sums them,
// tapers the sums by game phase and presents one saturated signed score until cleared.
module evaluate_taper #(
  parameter int EVAL_WIDTH  = 24,
  parameter int NUM_EVALS   = 4,
  parameter int PHASE_WIDTH = 5,
  parameter int PHASE_MAX   = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            board_valid,
  input  logic                            clear_eval,
  input  logic [PHASE_WIDTH-1:0]          phase,
  input  logic [NUM_EVALS-1:0]            eval_valid_in,
  input  logic [NUM_EVALS*EVAL_WIDTH-1:0] eval_mg_in,
  input  logic [NUM_EVALS*EVAL_WIDTH-1:0] eval_eg_in,
  output logic [EVAL_WIDTH-1:0]           eval,
  output logic                            eval_valid
);

  localparam int ACC_W  = EVAL_WIDTH + $clog2(NUM_EVALS) + 1;
  localparam int PROD_W = ACC_W + PHASE_WIDTH + 2;
  localparam int IDX_W  = $clog2(NUM_EVALS + 1);

  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SUM, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [PHASE_WIDTH-1:0]   phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_mg_q, acc_mg_d;
  logic signed [ACC_W-1:0]  acc_eg_q, acc_eg_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [EVAL_WIDTH-1:0]    eval_q, eval_d;
  logic                     eval_valid_q, eval_valid_d;

  logic signed [EVAL_WIDTH-1:0] slot_mg, slot_eg;
  logic signed [PROD_W-1:0]     acc_mg_x, acc_eg_x, ph_x, ph_inv_x, quot;
  logic [PHASE_WIDTH-1:0]       phase_clamped;

  // Slot mux over the live inputs; evaluators hold them stable while summing.
  always_comb begin
    slot_mg = '0;
    slot_eg = '0;
    for (int i = 0; i < NUM_EVALS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slot_mg = eval_mg_in[i*EVAL_WIDTH +: EVAL_WIDTH];
        slot_eg = eval_eg_in[i*EVAL_WIDTH +: EVAL_WIDTH];
      end
    end
  end

  assign phase_clamped = (phase > PHASE_WIDTH'(PHASE_MAX)) ? PHASE_WIDTH'(PHASE_MAX) : phase;
  assign acc_mg_x      = PROD_W'(acc_mg_q);
  assign acc_eg_x      = PROD_W'(acc_eg_q);
  assign ph_x          = PROD_W'({1'b0, phase_q});
  assign ph_inv_x      = PROD_W'(PHASE_MAX) - ph_x;
  // Signed division truncates toward zero.
  assign quot          = prod_q / $signed(PROD_W'(PHASE_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      acc_mg_q     <= '0;
      acc_eg_q     <= '0;
      idx_q        <= '0;
      prod_q       <= '0;
      eval_q       <= '0;
      eval_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      acc_mg_q     <= acc_mg_d;
      acc_eg_q     <= acc_eg_d;
      idx_q        <= idx_d;
      prod_q       <= prod_d;
      eval_q       <= eval_d;
      eval_valid_q <= eval_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_eval) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (board_valid) state_d = S_WAIT;
        S_WAIT: if (&eval_valid_in) state_d = S_SUM;
        S_SUM:  if (idx_q == IDX_W'(NUM_EVALS)) state_d = S_MUL;
        S_MUL:  state_d = S_DIV;
        S_DIV:  state_d = S_DONE;
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    phase_d      = phase_q;
    acc_mg_d     = acc_mg_q;
    acc_eg_d     = acc_eg_q;
    idx_d        = idx_q;
    prod_d       = prod_q;
    eval_d       = eval_q;
    eval_valid_d = eval_valid_q;
    case (state_q)
      S_IDLE: if (board_valid) phase_d = phase_clamped;
      S_WAIT: begin
        if (&eval_valid_in) begin
          acc_mg_d = '0;
          acc_eg_d = '0;
          idx_d    = '0;
        end
      end
      // One extra SUM cycle with idx == NUM_EVALS closes the loop before MUL.
      S_SUM: begin
        if (idx_q < IDX_W'(NUM_EVALS)) begin
          acc_mg_d = acc_mg_q + ACC_W'(slot_mg);
          acc_eg_d = acc_eg_q + ACC_W'(slot_eg);
          idx_d    = idx_q + 1'b1;
        end
      end
      S_MUL: prod_d = acc_mg_x * ph_x + acc_eg_x * ph_inv_x;
      S_DIV: begin
        if (quot > SAT_MAX)      eval_d = SAT_MAX[EVAL_WIDTH-1:0];
        else if (quot < SAT_MIN) eval_d = SAT_MIN[EVAL_WIDTH-1:0];
        else                     eval_d = quot[EVAL_WIDTH-1:0];
        eval_valid_d = 1'b1;
      end
      default: ;
    endcase
    if (clear_eval) begin
      eval_d       = eval_q;
      eval_valid_d = 1'b0;
    end
  end

  assign eval       = eval_q;
  assign eval_valid = eval_valid_q;

endmodule

// File: tb/tb_evaluate_taper.sv
// Table-driven, hand-sequenced and randomized checks of evaluate_taper against a plain
// arithmetic model of the phase taper.
module tb_evaluate_taper;
  localparam int EW = 24;
  localparam int NE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             board_valid;
  logic             clear_eval;
  logic [4:0]       phase;
  logic [NE-1:0]    eval_valid_in;
  logic [NE*EW-1:0] eval_mg_in;
  logic [NE*EW-1:0] eval_eg_in;
  logic [EW-1:0]    eval;
  logic             eval_valid;

  int total = 0;
  int bad   = 0;
  int cur_mg[NE];
  int cur_eg[NE];

  typedef struct {
    int mg[NE];
    int eg[NE];
    int ph;
    int exp;
  } vec_t;
  vec_t vecs[8];

  evaluate_taper dut (
    .clk(clk), .reset(reset), .board_valid(board_valid), .clear_eval(clear_eval),
    .phase(phase), .eval_valid_in(eval_valid_in), .eval_mg_in(eval_mg_in),
    .eval_eg_in(eval_eg_in), .eval(eval), .eval_valid(eval_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic load();
    for (int i = 0; i < NE; i++) begin
      eval_mg_in[i*EW +: EW] = cur_mg[i][EW-1:0];
      eval_eg_in[i*EW +: EW] = cur_eg[i][EW-1:0];
    end
  endtask

  function automatic int model(input int ph);
    longint smg = 0;
    longint seg = 0;
    longint p, q;
    for (int i = 0; i < NE; i++) begin
      smg += cur_mg[i];
      seg += cur_eg[i];
    end
    p = (ph > 24) ? 24 : ph;
    q = (smg * p + seg * (24 - p)) / 24;
    if (q > 8388607)  q = 8388607;
    if (q < -8388608) q = -8388608;
    return int'(q);
  endfunction

  function automatic int dut_eval();
    int v;
    v = $signed(eval);
    return v;
  endfunction

  // Full evaluation: start, raise all valids, measure edges from T to eval_valid, then clear.
  task automatic run(input int ph, output int got, output int lat);
    load();
    phase = ph[4:0];
    board_valid = 1'b1;
    eval_valid_in = '0;
    tick(); tick();
    eval_valid_in = '1;
    tick();
    lat = 0;
    while (!eval_valid && lat < 30) begin tick(); lat++; end
    got = dut_eval();
    clear_eval = 1'b1; board_valid = 1'b0; eval_valid_in = '0;
    tick();
    chk("clear_drops_valid", int'(eval_valid), 0);
    clear_eval = 1'b0;
    tick();
  endtask

  initial begin
    int got, lat, n, seen, exp;
    vecs[0] = '{mg:'{10,20,30,40}, eg:'{-5,-5,-5,-5}, ph:24, exp:100};
    vecs[1] = '{mg:'{10,20,30,40}, eg:'{-5,-5,-5,-5}, ph:0,  exp:-20};
    vecs[2] = '{mg:'{10,20,30,40}, eg:'{-5,-5,-5,-5}, ph:12, exp:40};
    vecs[3] = '{mg:'{10,20,30,40}, eg:'{-5,-5,-5,-5}, ph:31, exp:100};
    vecs[4] = '{mg:'{1,0,0,0},     eg:'{0,0,0,0},     ph:1,  exp:0};
    vecs[5] = '{mg:'{-25,0,0,0},   eg:'{0,0,0,0},     ph:1,  exp:-1};
    vecs[6] = '{mg:'{8388607,8388607,8388607,8388607}, eg:'{0,0,0,0}, ph:24, exp:8388607};
    vecs[7] = '{mg:'{-8388608,-8388608,-8388608,-8388608}, eg:'{0,0,0,0}, ph:24, exp:-8388608};

    reset = 1'b0; board_valid = 1'b0; clear_eval = 1'b0; phase = '0;
    eval_valid_in = '0; eval_mg_in = '0; eval_eg_in = '0;
    tick(); tick();
    chk("reset_eval", dut_eval(), 0);
    chk("reset_valid", int'(eval_valid), 0);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      cur_mg = vecs[v].mg;
      cur_eg = vecs[v].eg;
      run(vecs[v].ph, got, lat);
      chk($sformatf("vec%0d_eval", v), got, vecs[v].exp);
      chk($sformatf("vec%0d_latency", v), lat, 7);
    end

    // Staggered valids, then clear pulse and automatic restart.
    cur_mg = '{10,20,30,40}; cur_eg = '{-5,-5,-5,-5};
    load();
    phase = 5'd24; board_valid = 1'b1; eval_valid_in = 4'b0111;
    repeat (10) tick();
    chk("stagger_waiting", int'(eval_valid), 0);
    eval_valid_in = 4'b1111;
    tick();
    n = 0;
    while (!eval_valid && n < 30) begin tick(); n++; end
    chk("stagger_latency", n, 7);
    chk("stagger_eval", dut_eval(), 100);
    repeat (3) tick();
    chk("done_holds_valid", int'(eval_valid), 1);
    chk("done_holds_eval", dut_eval(), 100);
    clear_eval = 1'b1;
    tick();
    chk("pulse_clear_valid", int'(eval_valid), 0);
    chk("pulse_clear_keeps_eval", dut_eval(), 100);
    clear_eval = 1'b0;
    cur_mg = '{1,2,3,4}; cur_eg = '{100,0,0,0};
    load();
    n = 0;
    while (!eval_valid && n < 30) begin tick(); n++; end
    chk("restart_latency", n, 9);
    chk("restart_eval", dut_eval(), model(24));
    clear_eval = 1'b1; board_valid = 1'b0; eval_valid_in = '0;
    tick();
    clear_eval = 1'b0;
    tick();

    // Reset during SUM.
    cur_mg = '{10,20,30,40}; cur_eg = '{-5,-5,-5,-5};
    load();
    phase = 5'd24; board_valid = 1'b1;
    tick(); tick();
    eval_valid_in = '1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("sum_reset_valid", int'(eval_valid), 0);
    chk("sum_reset_eval", dut_eval(), 0);
    reset = 1'b1; board_valid = 1'b0; eval_valid_in = '0;
    seen = 0;
    repeat (12) begin tick(); if (eval_valid) seen = 1; end
    chk("sum_reset_no_result", seen, 0);

    // clear_eval while in MUL.
    phase = 5'd24; board_valid = 1'b1;
    tick(); tick();
    eval_valid_in = '1;
    tick();
    repeat (5) tick();
    clear_eval = 1'b1;
    tick();
    clear_eval = 1'b0; board_valid = 1'b0; eval_valid_in = '0;
    seen = 0;
    repeat (12) begin if (eval_valid) seen = 1; tick(); end
    chk("mul_clear_no_result", seen, 0);

    // Randomized against the model.
    for (int r = 0; r < 30; r++) begin
      int ph;
      for (int i = 0; i < NE; i++) begin
        int x;
        x = $urandom;
        cur_mg[i] = (r % 3 == 0) ? (x >>> 8) : (x >>> 20);
        x = $urandom;
        cur_eg[i] = (r % 3 == 1) ? (x >>> 8) : (x >>> 20);
      end
      ph = $urandom_range(0, 31);
      exp = model(ph);
      run(ph, got, lat);
      chk($sformatf("rand%0d_eval", r), got, exp);
      chk($sformatf("rand%0d_latency", r), lat, 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
